// File: rtl/ram_arbiter_rr_pkg.sv
// Shared types for the multi-core RAM arbiter: data word, RAM handshake
// state and the arbiter FSM state, plus a cyclic slot increment helper.
package ram_arbiter_rr_pkg;

    localparam int CPUS_DEF   = 2;
    localparam int WORD_W_DEF = 32;

    typedef logic [WORD_W_DEF-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Next slot after s in a ring of n slots.
    function automatic int next_slot(input int s, input int n);
        return (s + 1 >= n) ? 0 : s + 1;
    endfunction

endpackage

// File: rtl/ram_arbiter_rr_pick.sv
// Cyclic priority encoder: returns the first asserted request at or after
// i_ptr, wrapping around the N slots.
module ram_arbiter_rr_pick #(
    parameter int N  = 4,
    parameter int SW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [SW-1:0] i_ptr,
    output logic [SW-1:0] o_idx,
    output logic          o_valid
);

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        int            w_s;
        logic [SW-1:0] w_cand;
        o_idx   = '0;
        o_valid = 1'b0;
        w_s     = 0;
        w_cand  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            w_s = int'(i_ptr) + i;
            if (w_s >= N) begin
                w_s = w_s - N;
            end
            w_cand = SW'(w_s);
            if (i_req[w_cand]) begin
                o_idx   = w_cand;
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_arbiter_rr.sv
// Registered round-robin arbiter sharing one RAM port between the icache
// and dcache of CPUS cores. Slot 2k is dcache k, slot 2k+1 is icache k.
// A grant is held for one full RAM transaction (ACCESS or ERROR) or until
// the granted requester withdraws.
module ram_arbiter_rr
    import ram_arbiter_rr_pkg::*;
#(
    parameter int CPUS   = CPUS_DEF,
    parameter int WORD_W = WORD_W_DEF
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [CPUS-1:0]          i_iren,
    input  logic [CPUS-1:0]          i_dren,
    input  logic [CPUS-1:0]          i_dwen,
    input  logic [CPUS*WORD_W-1:0]   i_iaddr,
    input  logic [CPUS*WORD_W-1:0]   i_daddr,
    input  logic [CPUS*WORD_W-1:0]   i_dstore,
    output logic [CPUS-1:0]          o_iwait,
    output logic [CPUS-1:0]          o_dwait,
    output logic [CPUS*WORD_W-1:0]   o_iload,
    output logic [CPUS*WORD_W-1:0]   o_dload,
    output logic                     o_ram_ren,
    output logic                     o_ram_wen,
    output logic [WORD_W-1:0]        o_ram_addr,
    output logic [WORD_W-1:0]        o_ram_store,
    input  logic [WORD_W-1:0]        i_ram_load,
    input  logic [1:0]               i_ram_state,
    output logic                     o_ram_err
);

    localparam int N  = 2 * CPUS;
    localparam int SW = $clog2(N);
    localparam int CW = (CPUS > 1) ? $clog2(CPUS) : 1;

    arb_state_t    r_state;
    arb_state_t    w_state_nxt;
    logic [SW-1:0] r_rr_ptr;
    logic [SW-1:0] r_gnt;
    logic [SW-1:0] w_rr_ptr_nxt;
    logic [SW-1:0] w_gnt_nxt;
    logic [N-1:0]  w_req;
    logic [SW-1:0] w_pick_idx;
    logic          w_pick_valid;
    logic          w_gnt_req;
    logic [CW-1:0] w_gnt_core;
    ramstate_t     w_rs;

    for (genvar k = 0; k < CPUS; k++) begin : g_req
        assign w_req[2*k]   = i_dren[k] | i_dwen[k];
        assign w_req[2*k+1] = i_iren[k];
    end

    assign w_gnt_req  = w_req[r_gnt];
    assign w_gnt_core = CW'(r_gnt >> 1);
    assign w_rs       = ramstate_t'(i_ram_state);

    ram_arbiter_rr_pick #(
        .N  (N),
        .SW (SW)
    ) u_pick (
        .i_req   (w_req),
        .i_ptr   (r_rr_ptr),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    // State, round-robin pointer and grant registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_rr_ptr <= '0;
            r_gnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
            r_gnt    <= w_gnt_nxt;
        end
    end

    // Next state: grant on any request, release on termination or withdrawal.
    always_comb begin
        w_state_nxt  = r_state;
        w_rr_ptr_nxt = r_rr_ptr;
        w_gnt_nxt    = r_gnt;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_gnt_nxt   = w_pick_idx;
                    w_state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (!w_gnt_req) begin
                    // Withdrawn request: the pointer stays so the slot keeps its turn.
                    w_state_nxt = IDLE;
                end else if (w_rs == ACCESS || w_rs == ERROR) begin
                    w_state_nxt  = IDLE;
                    w_rr_ptr_nxt = SW'(next_slot(int'(r_gnt), N));
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output mux: RAM side follows the granted slot, requester side sees
    // wait=1/load=0 except the granted slot on its ACCESS cycle.
    always_comb begin
        o_iwait     = '1;
        o_dwait     = '1;
        o_iload     = '0;
        o_dload     = '0;
        o_ram_ren   = 1'b0;
        o_ram_wen   = 1'b0;
        o_ram_addr  = '0;
        o_ram_store = '0;
        o_ram_err   = 1'b0;
        if (r_state == GRANT) begin
            for (int k = 0; k < CPUS; k++) begin
                if (CW'(k) == w_gnt_core) begin
                    if (r_gnt[0]) begin
                        o_ram_addr = i_iaddr[k*WORD_W +: WORD_W];
                        if (w_gnt_req) begin
                            o_ram_ren = 1'b1;
                            if (w_rs == ACCESS) begin
                                o_iwait[k]                 = 1'b0;
                                o_iload[k*WORD_W +: WORD_W] = i_ram_load;
                            end
                        end
                    end else begin
                        o_ram_addr  = i_daddr[k*WORD_W +: WORD_W];
                        o_ram_store = i_dstore[k*WORD_W +: WORD_W];
                        if (w_gnt_req) begin
                            // Write wins when both read and write are requested.
                            o_ram_wen = i_dwen[k];
                            o_ram_ren = i_dren[k] & ~i_dwen[k];
                            if (w_rs == ACCESS) begin
                                o_dwait[k]                 = 1'b0;
                                o_dload[k*WORD_W +: WORD_W] = i_ram_load;
                            end
                        end
                    end
                end
            end
            o_ram_err = w_gnt_req && (w_rs == ERROR);
        end
    end

endmodule

// File: tb/tb_ram_arbiter_rr.sv
// Directed bench for ram_arbiter_rr: a per-cycle vector table of inputs and
// hand-computed outputs, followed by hand-written hold and async-reset sequences.
module tb_ram_arbiter_rr;
    import ram_arbiter_rr_pkg::*;

    localparam logic [31:0] AD0 = 32'h0000_0100;
    localparam logic [31:0] SD0 = 32'hDEAD_BEEF;
    localparam logic [31:0] AI0 = 32'h0000_0040;
    localparam logic [31:0] AD1 = 32'h0000_0200;
    localparam logic [31:0] SD1 = 32'h1234_5678;
    localparam logic [31:0] AI1 = 32'h0000_0080;
    localparam int NV = 41;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  iren = '0, dren = '0, dwen = '0;
    logic [63:0] iaddr, daddr, dstore;
    logic [1:0]  iwait, dwait;
    logic [63:0] iload, dload;
    logic        ram_ren, ram_wen, ram_err;
    logic [31:0] ram_addr, ram_store;
    logic [31:0] ram_load = '0;
    logic [1:0]  ram_state = FREE;

    int n_chk = 0;
    int n_err = 0;

    assign iaddr  = {AI1, AI0};
    assign daddr  = {AD1, AD0};
    assign dstore = {SD1, SD0};

    always #5 clk = ~clk;

    ram_arbiter_rr #(.CPUS(2), .WORD_W(32)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_iren      (iren),
        .i_dren      (dren),
        .i_dwen      (dwen),
        .i_iaddr     (iaddr),
        .i_daddr     (daddr),
        .i_dstore    (dstore),
        .o_iwait     (iwait),
        .o_dwait     (dwait),
        .o_iload     (iload),
        .o_dload     (dload),
        .o_ram_ren   (ram_ren),
        .o_ram_wen   (ram_wen),
        .o_ram_addr  (ram_addr),
        .o_ram_store (ram_store),
        .i_ram_load  (ram_load),
        .i_ram_state (ram_state),
        .o_ram_err   (ram_err)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  iren, dren, dwen;
        logic [1:0]  rs;
        logic [31:0] ld;
        logic        ren, wen;
        logic [31:0] addr, store;
        logic [1:0]  iw, dw;
        logic [63:0] il, dl;
        logic        err;
    } vec_t;

    vec_t tv [NV];

    function automatic vec_t mk(input logic r, input logic [1:0] ir, dr, dw_in,
                                input logic [1:0] rs, input logic [31:0] ld,
                                input logic ren, wen, input logic [31:0] addr, store,
                                input logic [1:0] iw, dw, input logic [63:0] il, dl,
                                input logic err);
        vec_t v;
        v.rst = r; v.iren = ir; v.dren = dr; v.dwen = dw_in; v.rs = rs; v.ld = ld;
        v.ren = ren; v.wen = wen; v.addr = addr; v.store = store;
        v.iw = iw; v.dw = dw; v.il = il; v.dl = dl; v.err = err;
        return v;
    endfunction

    // Idle-output vector (arbiter in IDLE or reset).
    function automatic vec_t mki(input logic r, input logic [1:0] ir, dr, dw_in);
        return mk(r, ir, dr, dw_in, FREE, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                  2'b11, 2'b11, 64'h0, 64'h0, 1'b0);
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_vec(input int i, input vec_t v);
        check($sformatf("v%0d ram_ren", i),   64'(ram_ren),   64'(v.ren));
        check($sformatf("v%0d ram_wen", i),   64'(ram_wen),   64'(v.wen));
        check($sformatf("v%0d ram_addr", i),  64'(ram_addr),  64'(v.addr));
        check($sformatf("v%0d ram_store", i), 64'(ram_store), 64'(v.store));
        check($sformatf("v%0d iwait", i),     64'(iwait),     64'(v.iw));
        check($sformatf("v%0d dwait", i),     64'(dwait),     64'(v.dw));
        check($sformatf("v%0d iload", i),     iload,          v.il);
        check($sformatf("v%0d dload", i),     dload,          v.dl);
        check($sformatf("v%0d ram_err", i),   64'(ram_err),   64'(v.err));
    endtask

    initial begin
        tv[0]  = mki(1, 2'b00, 2'b00, 2'b00);
        // single i-fetch on slot 1
        tv[1]  = mki(0, 2'b01, 2'b00, 2'b00);
        tv[2]  = mk(0, 2'b01, 2'b00, 2'b00, BUSY,   32'h1111_1111, 1, 0, AI0, 0, 2'b11, 2'b11, 64'h0, 64'h0, 0);
        tv[3]  = mk(0, 2'b01, 2'b00, 2'b00, ACCESS, 32'h2222_2222, 1, 0, AI0, 0, 2'b10, 2'b11, {32'h0, 32'h2222_2222}, 64'h0, 0);
        tv[4]  = mki(0, 2'b00, 2'b00, 2'b00);
        // write beats read on slot 0
        tv[5]  = mki(0, 2'b00, 2'b01, 2'b01);
        tv[6]  = mk(0, 2'b00, 2'b01, 2'b01, BUSY,   32'h0, 0, 1, AD0, SD0, 2'b11, 2'b11, 64'h0, 64'h0, 0);
        tv[7]  = mk(0, 2'b00, 2'b01, 2'b01, ACCESS, 32'h3333_3333, 0, 1, AD0, SD0, 2'b11, 2'b10, 64'h0, {32'h0, 32'h3333_3333}, 0);
        tv[8]  = mki(0, 2'b00, 2'b00, 2'b00);
        // reset, then all four slots requesting
        tv[9]  = mki(1, 2'b00, 2'b00, 2'b00);
        tv[10] = mki(0, 2'b11, 2'b11, 2'b00);
        tv[11] = mk(0, 2'b11, 2'b11, 2'b00, BUSY,   32'h0, 1, 0, AD0, SD0, 2'b11, 2'b11, 64'h0, 64'h0, 0);
        tv[12] = mk(0, 2'b11, 2'b11, 2'b00, ACCESS, 32'h4444_4444, 1, 0, AD0, SD0, 2'b11, 2'b10, 64'h0, {32'h0, 32'h4444_4444}, 0);
        tv[13] = mki(0, 2'b11, 2'b11, 2'b00);
        tv[14] = mk(0, 2'b11, 2'b11, 2'b00, BUSY,   32'h0, 1, 0, AI0, 0, 2'b11, 2'b11, 64'h0, 64'h0, 0);
        tv[15] = mk(0, 2'b11, 2'b11, 2'b00, ACCESS, 32'h5555_5555, 1, 0, AI0, 0, 2'b10, 2'b11, {32'h0, 32'h5555_5555}, 64'h0, 0);
        tv[16] = mki(0, 2'b11, 2'b11, 2'b00);
        tv[17] = mk(0, 2'b11, 2'b11, 2'b00, BUSY,   32'h0, 1, 0, AD1, SD1, 2'b11, 2'b11, 64'h0, 64'h0, 0);
        tv[18] = mk(0, 2'b11, 2'b11, 2'b00, ACCESS, 32'h6666_6666, 1, 0, AD1, SD1, 2'b11, 2'b01, 64'h0, {32'h6666_6666, 32'h0}, 0);
        tv[19] = mki(0, 2'b11, 2'b11, 2'b00);
        tv[20] = mk(0, 2'b11, 2'b11, 2'b00, BUSY,   32'h0, 1, 0, AI1, 0, 2'b11, 2'b11, 64'h0, 64'h0, 0);
        tv[21] = mk(0, 2'b11, 2'b11, 2'b00, ACCESS, 32'h7777_7777, 1, 0, AI1, 0, 2'b01, 2'b11, {32'h7777_7777, 32'h0}, 64'h0, 0);
        tv[22] = mki(0, 2'b11, 2'b11, 2'b00);
        tv[23] = mk(0, 2'b11, 2'b11, 2'b00, BUSY,   32'h0, 1, 0, AD0, SD0, 2'b11, 2'b11, 64'h0, 64'h0, 0);
        // everyone withdraws while slot 0 is granted
        tv[24] = mk(0, 2'b00, 2'b00, 2'b00, BUSY,   32'h0, 0, 0, AD0, SD0, 2'b11, 2'b11, 64'h0, 64'h0, 0);
        tv[25] = mki(0, 2'b00, 2'b00, 2'b00);
        // ERROR on dREN1, next grant to slot 3
        tv[26] = mki(0, 2'b10, 2'b10, 2'b00);
        tv[27] = mk(0, 2'b10, 2'b10, 2'b00, BUSY,   32'h0, 1, 0, AD1, SD1, 2'b11, 2'b11, 64'h0, 64'h0, 0);
        tv[28] = mk(0, 2'b10, 2'b10, 2'b00, ERROR,  32'hEEEE_EEEE, 1, 0, AD1, SD1, 2'b11, 2'b11, 64'h0, 64'h0, 1);
        tv[29] = mki(0, 2'b10, 2'b10, 2'b00);
        tv[30] = mk(0, 2'b10, 2'b10, 2'b00, BUSY,   32'h0, 1, 0, AI1, 0, 2'b11, 2'b11, 64'h0, 64'h0, 0);
        // abort: iREN1 drops under BUSY; pointer must still favour slot 3
        tv[31] = mk(0, 2'b00, 2'b10, 2'b00, BUSY,   32'h0, 0, 0, AI1, 0, 2'b11, 2'b11, 64'h0, 64'h0, 0);
        tv[32] = mki(0, 2'b10, 2'b10, 2'b00);
        tv[33] = mk(0, 2'b10, 2'b10, 2'b00, BUSY,   32'h0, 1, 0, AI1, 0, 2'b11, 2'b11, 64'h0, 64'h0, 0);
        tv[34] = mk(0, 2'b10, 2'b10, 2'b00, ACCESS, 32'h8888_8888, 1, 0, AI1, 0, 2'b01, 2'b11, {32'h8888_8888, 32'h0}, 64'h0, 0);
        // reset mid-GRANT with dWEN0, then re-grant
        tv[35] = mki(0, 2'b00, 2'b00, 2'b01);
        tv[36] = mk(0, 2'b00, 2'b00, 2'b01, BUSY,   32'h0, 0, 1, AD0, SD0, 2'b11, 2'b11, 64'h0, 64'h0, 0);
        tv[37] = mk(1, 2'b00, 2'b00, 2'b01, BUSY,   32'h0, 0, 0, 32'h0, 32'h0, 2'b11, 2'b11, 64'h0, 64'h0, 0);
        tv[38] = mki(0, 2'b00, 2'b00, 2'b01);
        tv[39] = mk(0, 2'b00, 2'b00, 2'b01, ACCESS, 32'h9999_9999, 0, 1, AD0, SD0, 2'b11, 2'b10, 64'h0, {32'h0, 32'h9999_9999}, 0);
        tv[40] = mki(0, 2'b00, 2'b00, 2'b00);

        for (int i = 0; i < NV; i++) begin
            @(posedge clk); #1;
            rst       = tv[i].rst;
            iren      = tv[i].iren;
            dren      = tv[i].dren;
            dwen      = tv[i].dwen;
            ram_state = tv[i].rs;
            ram_load  = tv[i].ld;
            @(negedge clk);
            check_vec(i, tv[i]);
        end

        // Hold: slot 3 granted, FREE/BUSY for six cycles keeps the RAM side stable.
        @(posedge clk); #1;
        iren = 2'b10; dren = 2'b00; dwen = 2'b00; ram_state = FREE; ram_load = 32'h0;
        @(negedge clk);
        check("hold idle ren", 64'(ram_ren), 64'(0));
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            ram_state = (c % 2 == 0) ? FREE : BUSY;
            @(negedge clk);
            check($sformatf("hold c%0d ren", c),   64'(ram_ren),  64'(1));
            check($sformatf("hold c%0d addr", c),  64'(ram_addr), 64'(AI1));
            check($sformatf("hold c%0d iwait", c), 64'(iwait),    64'(2'b11));
        end
        @(posedge clk); #1;
        ram_state = ACCESS; ram_load = 32'hABCD_1234;
        @(negedge clk);
        check("hold done iwait", 64'(iwait), 64'(2'b01));
        check("hold done iload", iload, {32'hABCD_1234, 32'h0});

        // Async reset pulsed between edges during a slot 2 write.
        @(posedge clk); #1;
        iren = 2'b00; dwen = 2'b10; ram_state = FREE; ram_load = 32'h0;
        @(posedge clk); #1;
        ram_state = BUSY;
        @(negedge clk);
        check("arst pre wen",  64'(ram_wen),  64'(1));
        check("arst pre addr", 64'(ram_addr), 64'(AD1));
        #2 rst = 1'b1;
        #1;
        check("arst wen",   64'(ram_wen),   64'(0));
        check("arst ren",   64'(ram_ren),   64'(0));
        check("arst dwait", 64'(dwait),     64'(2'b11));
        check("arst store", 64'(ram_store), 64'(0));
        #1 rst = 1'b0;
        @(negedge clk);
        check("arst regrant wen",   64'(ram_wen),   64'(1));
        check("arst regrant store", 64'(ram_store), 64'(SD1));
        @(posedge clk); #1;
        ram_state = ACCESS; ram_load = 32'h5A5A_A5A5;
        @(negedge clk);
        check("arst done dwait", 64'(dwait), 64'(2'b01));
        check("arst done dload", dload, {32'h5A5A_A5A5, 32'h0});
        @(posedge clk); #1;
        dwen = 2'b00; ram_state = FREE;
        @(negedge clk);
        check("final idle dwait", 64'(dwait), 64'(2'b11));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
